// File: rtl/rkey_store_ctrl.sv
// Multi-context AES round-key store: fills per-context schedules and replays them forward/reverse.
// Optional RKEY_ZEROIZE_EN adds a zeroize port that wipes one idle context in a single cycle.
module rkey_store_ctrl #(
  parameter int KEY_W = 128,
  parameter int NCTX  = 2,
  parameter int DEPTH = 15,
  parameter int CTX_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [CTX_W-1:0] ctx_sel,
  input  logic             gen_start,
  input  logic             wr_valid,
  input  logic [KEY_W-1:0] wr_data,
  output logic             fill_done,
  input  logic             rd_start,
  input  logic             rd_dec,
  input  logic             rd_step,
  output logic [KEY_W-1:0] rkey_out,
  output logic             rkey_valid,
  output logic             rkey_last,
  output logic [NCTX-1:0]  ctx_ready,
  output logic             busy,
`ifdef RKEY_ZEROIZE_EN
  input  logic             zeroize,
`endif
  output logic             err
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, READ} state_t;

  function automatic int last_of(input logic [1:0] m);
    case (m)
      2'd2:    return 12;
      2'd3:    return 14;
      default: return 10;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [KEY_W-1:0] mem [NCTX][DEPTH];
  logic [1:0]       ctx_mode [NCTX];
  logic [CTX_W-1:0] ctx_q;
  logic [1:0]       mode_q;
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_end, rd_first, rd_nx, fill_last;
  logic             dec_q;
  logic             zero_req;
  logic             gen_go, rd_go, wr_go, fill_end, step_go, zero_go, err_d;

`ifdef RKEY_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign fill_last = PW'(last_of(mode_q));
  assign rd_first  = rd_dec ? PW'(last_of(ctx_mode[ctx_sel])) : '0;
  assign rd_end    = dec_q ? '0 : PW'(last_of(ctx_mode[ctx_q]));
  assign rd_nx     = dec_q ? rd_ptr - 1'b1 : rd_ptr + 1'b1;

  assign busy       = (state_q != IDLE);
  assign rkey_valid = (state_q == READ);
  assign rkey_last  = rkey_valid && (rd_ptr == rd_end);

  always_comb begin
    state_d  = state_q;
    gen_go   = 1'b0;
    rd_go    = 1'b0;
    wr_go    = 1'b0;
    fill_end = 1'b0;
    step_go  = 1'b0;
    zero_go  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (zero_req) begin
          zero_go = 1'b1;
        end else if (gen_start) begin
          // a simultaneous rd_start is dropped and flagged
          err_d = rd_start;
          if (last_of(mode) >= DEPTH) begin
            err_d = 1'b1;
          end else begin
            gen_go  = 1'b1;
            state_d = FILL;
          end
        end else if (rd_start) begin
          if (ctx_ready[ctx_sel]) begin
            rd_go   = 1'b1;
            state_d = READ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FILL: begin
        err_d = gen_start | rd_start | zero_req;
        if (wr_valid) begin
          wr_go = 1'b1;
          if (wr_ptr == fill_last) begin
            fill_end = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      READ: begin
        err_d = gen_start | rd_start | zero_req;
        if (rd_step) begin
          if (rd_ptr == rd_end) state_d = IDLE;
          else                  step_go = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Key storage and per-context mode are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_go) mem[ctx_q][wr_ptr] <= wr_data;
    if (zero_go) begin
      for (int d = 0; d < DEPTH; d++) mem[ctx_sel][d] <= '0;
    end
    if (fill_end) ctx_mode[ctx_q] <= mode_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ctx_ready <= '0;
      rkey_out  <= '0;
      fill_done <= 1'b0;
      err       <= 1'b0;
      ctx_q     <= '0;
      mode_q    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      dec_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_done <= fill_end;
      err       <= err_d;
      if (gen_go) begin
        ctx_q              <= ctx_sel;
        mode_q             <= mode;
        wr_ptr             <= '0;
        ctx_ready[ctx_sel] <= 1'b0;
      end
      if (wr_go)    wr_ptr <= wr_ptr + 1'b1;
      if (fill_end) ctx_ready[ctx_q] <= 1'b1;
      if (zero_go)  ctx_ready[ctx_sel] <= 1'b0;
      if (rd_go) begin
        ctx_q    <= ctx_sel;
        dec_q    <= rd_dec;
        rd_ptr   <= rd_first;
        rkey_out <= mem[ctx_sel][rd_first];
      end
      if (step_go) begin
        rd_ptr   <= rd_nx;
        rkey_out <= mem[ctx_q][rd_nx];
      end
    end
  end

endmodule

// File: doc/rkey_store_ctrl.md
Name: rkey_store_ctrl

Overview:
- Multi-context round-key store and sequencer for the AES core.
- Captures round keys from the key-expansion datapath into per-context slots.
- Replays a stored schedule in forward order (encrypt) or reverse order (decrypt) with a registered output and a step handshake.
- Generalises the single-schedule address controller to NCTX contexts. Adds per-context stored mode, ready tracking, error flagging and a last-key marker.

Parameters:
- KEY_W, 128, round-key width in bits
- NCTX, 2, number of independent key contexts (at least 1)
- DEPTH, 15, slots per context; must be at least 15 to hold an AES256 schedule
- CTX_W, 1, width of ctx_sel (clog2(NCTX), minimum 1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mode  in  2  key size for gen_start: 2 = AES192, 3 = AES256, others = AES128
- ctx_sel  in  CTX_W  context addressed by gen_start / rd_start
- gen_start  in  1  begin a fill of ctx_sel
- wr_valid  in  1  wr_data holds the next round key
- wr_data  in  KEY_W  round key from key expansion
- fill_done  out  1  one-cycle pulse: schedule complete
- rd_start  in  1  begin replay of ctx_sel
- rd_dec  in  1  sampled with rd_start: 1 = reverse order, 0 = forward order
- rd_step  in  1  consume current key, advance
- rkey_out  out  KEY_W  current round key (registered)
- rkey_valid  out  1  rkey_out is valid
- rkey_last  out  1  rkey_out is the final key of the replay
- ctx_ready  out  NCTX  per-context schedule valid
- busy  out  1  state is not IDLE
- err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset values: state IDLE; all outputs 0 (rkey_out, fill_done, rkey_valid, rkey_last, ctx_ready, busy, err).
- Storage array is not reset.
- last(m) = 10 for AES128, 12 for AES192, 14 for AES256.
- Each context stores the mode captured at its fill. Replay uses that stored mode and ignores the mode input.

States:
- IDLE
  - gen_start: if last(mode) >= DEPTH, pulse err and stay in IDLE. Otherwise latch ctx and mode, clear ctx_ready[ctx], set wr_ptr = 0, go to FILL.
  - rd_start with ctx_ready[ctx_sel] = 0: pulse err and stay in IDLE.
  - rd_start with ctx_ready[ctx_sel] = 1: ptr = rd_dec ? last : 0; load rkey_out <= mem[ctx][ptr]; go to READ.
  - gen_start and rd_start in the same cycle: gen_start wins; rd_start is dropped and err pulses.
  - wr_valid and rd_step are ignored.
- FILL
  - Each wr_valid writes mem[ctx][wr_ptr] and increments wr_ptr.
  - wr_valid with wr_ptr == last: store the mode for ctx, set ctx_ready[ctx], pulse fill_done the next cycle, return to IDLE.
  - Exactly last+1 writes complete a fill.
  - gen_start or rd_start while in FILL: ignored, err pulses.
- READ
  - rkey_valid = 1; rkey_last = 1 when ptr equals the end index (last when forward, 0 when reverse).
  - rd_step when not at the end: ptr moves +1 (forward) or −1 (reverse); rkey_out updates in the next cycle (1-cycle latency).
  - rd_step at the end: go to IDLE; rkey_valid and rkey_last drop the next cycle; rkey_out holds its value.
  - There is no address wrap-around; ptr never leaves the range 0..last.
  - gen_start or rd_start while in READ: ignored, err pulses.

Other rules:
- busy = (state != IDLE).
- A fill of one context never disturbs ctx_ready of the other contexts.
- rst asserted mid-FILL or mid-READ: next cycle is IDLE with all outputs 0, including every ctx_ready bit. Storage is left stale and must be refilled before use.

Optional Feature:
- Macro RKEY_ZEROIZE_EN.
- Defined:
  - Adds port zeroize (in, 1).
  - In IDLE, zeroize clears all DEPTH slots of ctx_sel to 0 in one cycle and clears ctx_ready[ctx_sel].
  - Has priority over gen_start and rd_start in the same cycle; err is not pulsed.
  - Outside IDLE: ignored and err pulses.
- Undefined: the port does not exist and slots are only overwritten by fills.

Test Plan:
1. AES128 forward:
   - Stimulus: gen_start, ctx 0, mode 0; 11 writes of keys k0..k10 (value i in each word).
   - Required: fill_done exactly once, ctx_ready = 2'b01.
   - Then rd_start with rd_dec = 0 and 11 rd_steps.
   - Required: rkey_out = 0..10 in order; rkey_last only on 10; rkey_valid low the cycle after the final step.
2. AES256 reverse on ctx 1:
   - Stimulus: fill 15 keys (0..14), then rd_start with rd_dec = 1.
   - Required: rkey_out = 14, 13, ..., 0; rkey_last on 0; ctx 0 contents unchanged.
3. Errors:
   - rd_start on an unfilled ctx → err pulse, busy stays 0.
   - gen_start during FILL → err pulse, fill continues unaffected.
   - gen_start with rd_start in the same cycle → FILL entered, err pulse.
4. Stored mode:
   - Stimulus: fill ctx 0 as AES192, then rd_start with the mode input = 3.
   - Required: 13 keys replayed, rkey_last on index 12 (forward).
5. Reset mid-READ:
   - Stimulus: assert rst after 3 steps.
   - Required: next cycle rkey_valid = 0, ctx_ready = 0, busy = 0; a following rd_start → err pulse.
6. RKEY_ZEROIZE_EN build:
   - Stimulus: fill ctx 0, zeroize ctx 0, refill with only 5 keys, reset.
   - Required: after zeroize ctx_ready[0] = 0; after refill ctx_ready[0] stays 0; no stale nonzero key is ever presented.
